// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side packet parser: parser states, read latency
// and the canonical {data, last} buffer entry at the default byte width.
package fifo_pkg;

    localparam int FIFO_RD_LATENCY = 1;
    localparam int PKT_DATA_WIDTH  = 8;

    typedef enum logic {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } parse_state_t;

    typedef struct packed {
        logic [PKT_DATA_WIDTH-1:0] data;
        logic                      last;
    } pkt_entry_t;

endpackage

// File: rtl/pkt_skid_buf2.sv
// Two-entry circular buffer of {data, last} words with independent push/pop.
// The head entry is presented directly from storage, so it holds while not popped.
module pkt_skid_buf2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_head_ptr;
    logic             r_tail_ptr;
    logic [1:0]       r_occ;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Qualify requests: a pop frees a slot for a same-cycle push when full
    always_comb begin
        w_pop_ok  = i_pop && (r_occ != 2'd0);
        w_push_ok = i_push && ((r_occ != 2'd2) || w_pop_ok);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0]   <= {WIDTH{1'b0}};
            r_mem[1]   <= {WIDTH{1'b0}};
            r_head_ptr <= 1'b0;
            r_tail_ptr <= 1'b0;
            r_occ      <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_tail_ptr] <= i_push_data;
                r_tail_ptr        <= ~r_tail_ptr;
            end
            if (w_pop_ok) begin
                r_head_ptr <= ~r_head_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head = r_mem[r_head_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Read-side master for the synchronous FIFO: parses length-prefixed packets and
// streams their payload with m_last, sustaining one byte per cycle.
module fifo_pkt_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  pkt_err,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  in_packet
);

    parse_state_t          r_state;
    parse_state_t          w_state_next;
    logic [DATA_WIDTH-1:0] r_remaining;
    logic [DATA_WIDTH-1:0] w_remaining_next;
    logic                  r_inflight;
    logic                  r_pkt_err;
    logic [CNT_WIDTH-1:0]  r_pkt_count;
    logic                  w_push;
    logic                  w_push_last;
    logic                  w_hdr_err;
    logic                  w_pop;
    logic [DATA_WIDTH:0]   w_head;
    logic [1:0]            w_occ;
    logic [2:0]            w_credits_used;

    pkt_skid_buf2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data ({fifo_data_out, w_push_last}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    assign m_valid   = (w_occ != 2'd0);
    assign m_data    = w_head[DATA_WIDTH:1];
    assign m_last    = w_head[0];
    assign pkt_err   = r_pkt_err;
    assign pkt_count = r_pkt_count;
    assign in_packet = (r_state == PAYLOAD);

    // Read issue: headers also take a credit, and the m_ready path is deliberate for full rate
    always_comb begin
        w_pop          = m_valid && m_ready;
        w_credits_used = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        fifo_rd_en     = reset_n && enable && !fifo_empty && (w_credits_used < 3'd2);
    end

    // Parser state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= HDR;
            r_remaining <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
        end
    end

    // Parser next state, advanced only when a read byte arrives
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        if (r_inflight) begin
            case (r_state)
                HDR: begin
                    if (fifo_data_out != {DATA_WIDTH{1'b0}}) begin
                        w_state_next     = PAYLOAD;
                        w_remaining_next = fifo_data_out;
                    end else begin
                        w_state_next     = HDR;
                    end
                end
                PAYLOAD: begin
                    w_remaining_next = r_remaining - DATA_WIDTH'(1);
                    if (r_remaining == DATA_WIDTH'(1)) begin
                        w_state_next = HDR;
                    end else begin
                        w_state_next = PAYLOAD;
                    end
                end
                default: w_state_next = HDR;
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Parser outputs: payload pushes and the zero-length header flag
    always_comb begin
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_hdr_err   = 1'b0;
        if (r_inflight) begin
            case (r_state)
                HDR:     w_hdr_err = (fifo_data_out == {DATA_WIDTH{1'b0}});
                PAYLOAD: begin
                    w_push      = 1'b1;
                    w_push_last = (r_remaining == DATA_WIDTH'(1));
                end
                default: w_hdr_err = 1'b0;
            endcase
        end else begin
            w_push = 1'b0;
        end
    end

    // In-flight flag, error pulse and completed-packet counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight  <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_pkt_count <= {CNT_WIDTH{1'b0}};
        end else begin
            r_inflight <= fifo_rd_en;
            r_pkt_err  <= w_hdr_err;
            if (w_pop && w_head[0]) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Self-checking bench for fifo_pkt_reader: a queue-based FIFO model feeds the DUT and
// a length-prefix parser over the raw byte list predicts the payload stream.
module tb_fifo_pkt_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data_out = 8'h00;
    logic        m_ready = 1'b0;
    logic        fifo_rd_en, m_valid, m_last, pkt_err, in_packet;
    logic [7:0]  m_data;
    logic [15:0] pkt_count;

    int checks = 0;
    int failures = 0;

    byte unsigned fq[$];
    logic [8:0]   obs[$];
    int           obs_cyc[$];
    logic [8:0]   exp_q[$];
    int           exp_err, exp_pkts;
    int           cyc = 0;
    int           err_cycles, err_run, err_run_max, rd_bad, hold_bad;
    logic         stall_empty = 1'b0;
    logic         prev_hold = 1'b0;
    logic [8:0]   prev_beat = 9'h000;

    fifo_pkt_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .pkt_err       (pkt_err),
        .pkt_count     (pkt_count),
        .in_packet     (in_packet)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data one cycle after an accepted read
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty && fq.size() > 0) fifo_data_out <= fq.pop_front();
    end

    always @(negedge clk) begin
        #1;
        fifo_empty = stall_empty || (fq.size() == 0);
    end

    // Monitor: record accepted beats, error pulses, illegal reads and unstable held data
    always @(negedge clk) begin
        #2;
        cyc++;
        if (!reset_n) begin
            prev_hold = 1'b0;
        end else begin
            if (fifo_rd_en && (fifo_empty || !enable)) rd_bad++;
            if (prev_hold && (!m_valid || {m_data, m_last} !== prev_beat)) hold_bad++;
            prev_hold = m_valid && !m_ready;
            prev_beat = {m_data, m_last};
            if (pkt_err) begin
                err_cycles++;
                err_run++;
                if (err_run > err_run_max) err_run_max = err_run;
            end else begin
                err_run = 0;
            end
            if (m_valid && m_ready) begin
                obs.push_back({m_data, m_last});
                obs_cyc.push_back(cyc);
            end
        end
    end

    // Reference: walk the byte list as header + payload, ignoring any trailing partial packet
    task automatic model_parse(input byte unsigned b[$]);
        int i;
        int len;
        exp_q.delete();
        exp_err = 0;
        exp_pkts = 0;
        i = 0;
        while (i < b.size()) begin
            len = b[i];
            i++;
            if (len == 0) begin
                exp_err++;
            end else begin
                if (i + len > b.size()) break;
                for (int k = 0; k < len; k++) exp_q.push_back({b[i+k], (k == len - 1)});
                exp_pkts++;
                i += len;
            end
        end
    endtask

    task automatic load(input byte unsigned b[$]);
        foreach (b[i]) fq.push_back(b[i]);
    endtask

    task automatic clear_obs();
        obs.delete();
        obs_cyc.delete();
        err_cycles = 0;
        err_run = 0;
        err_run_max = 0;
        rd_bad = 0;
        hold_bad = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b1;
        m_ready = 1'b1;
        stall_empty = 1'b0;
        fq.delete();
        repeat (2) @(negedge clk);
        clear_obs();
        reset_n = 1'b1;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (obs.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        byte unsigned b[$];
        b = '{8'h02, 8'h10, 8'h20};
        reset_n = 1'b0;
        enable = 1'b1;
        m_ready = 1'b1;
        load(b);
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({fifo_rd_en, m_valid, m_data, m_last, pkt_err, pkt_count, in_packet} !== 30'h0) begin
            failures++;
            $display("FAIL reset_outputs got rd=%b v=%b d=%h l=%b e=%b c=%0d p=%b exp all zero",
                     fifo_rd_en, m_valid, m_data, m_last, pkt_err, pkt_count, in_packet);
        end
    endtask

    task automatic test_single();
        byte unsigned b[$];
        bit ok;
        do_reset();
        b = '{8'h03, 8'hA1, 8'hA2, 8'hA3};
        model_parse(b);
        load(b);
        wait_beats(3, 40, ok);
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (!ok || obs.size() !== 3) begin
            failures++;
            $display("FAIL single_count got=%0d exp=3", obs.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if (obs.size() < 3 || obs_cyc[2] - obs_cyc[0] != 2) begin
            failures++;
            $display("FAIL single_consecutive got beats=%0d exp 3 beats in 3 cycles", obs.size());
        end
        checks++;
        if (pkt_count !== 16'd1 || in_packet !== 1'b0) begin
            failures++;
            $display("FAIL single_end got count=%0d in_pkt=%b exp count=1 in_pkt=0", pkt_count, in_packet);
        end
    endtask

    task automatic test_back_to_back();
        byte unsigned b[$];
        bit ok;
        do_reset();
        b = '{8'h02, 8'h11, 8'h12, 8'h01, 8'h21};
        model_parse(b);
        load(b);
        wait_beats(3, 40, ok);
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (!ok || obs.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if (obs.size() < 3 || obs_cyc[1] - obs_cyc[0] != 1 || obs_cyc[2] - obs_cyc[1] != 2) begin
            failures++;
            $display("FAIL b2b_gaps got beats=%0d exp gaps 1 and 2 cycles", obs.size());
        end
        checks++;
        if (pkt_count !== exp_pkts[15:0]) begin
            failures++;
            $display("FAIL b2b_pkt_count got=%0d exp=%0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_backpressure();
        byte unsigned b[$];
        bit ok;
        do_reset();
        b = '{8'h04, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h02, 8'hC1, 8'hC2};
        model_parse(b);
        load(b);
        wait_beats(1, 40, ok);
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            if (k >= 2) begin
                checks++;
                if (fifo_rd_en !== 1'b0 || m_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_stall%0d got rd=%b valid=%b exp rd=0 valid=1", k, fifo_rd_en, m_valid);
                end
            end
            @(negedge clk);
        end
        m_ready = 1'b1;
        wait_beats(exp_q.size(), 60, ok);
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (!ok || obs.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if (hold_bad !== 0 || pkt_count !== 16'd2) begin
            failures++;
            $display("FAIL bp_hold got unstable=%0d count=%0d exp 0 and 2", hold_bad, pkt_count);
        end
    endtask

    task automatic test_zero_len();
        byte unsigned b[$];
        bit ok;
        do_reset();
        b = '{8'h00, 8'h01, 8'h5A};
        model_parse(b);
        load(b);
        wait_beats(1, 40, ok);
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (err_cycles !== exp_err || err_run_max !== 1) begin
            failures++;
            $display("FAIL zero_err got cycles=%0d run=%0d exp=%0d run 1", err_cycles, err_run_max, exp_err);
        end
        checks++;
        if (!ok || obs.size() !== 1 || obs[0] !== exp_q[0] || pkt_count !== 16'd1) begin
            failures++;
            $display("FAIL zero_payload got n=%0d count=%0d exp one beat 5A last, count 1", obs.size(), pkt_count);
        end
    endtask

    task automatic test_stall_enable();
        byte unsigned b1[$];
        byte unsigned b2[$];
        byte unsigned b3[$];
        byte unsigned all[$];
        bit ok;
        do_reset();
        b1 = '{8'h05, 8'hD1, 8'hD2};
        b2 = '{8'hD3, 8'hD4, 8'hD5};
        b3 = '{8'h06, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6};
        all = {b1, b2, b3};
        model_parse(all);
        load(b1);
        wait_beats(2, 40, ok);
        repeat (6) @(negedge clk);
        #2;
        checks++;
        if (!ok || in_packet !== 1'b1 || obs.size() !== 2 || fifo_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold got in_pkt=%b n=%0d rd=%b exp 1 2 0", in_packet, obs.size(), fifo_rd_en);
        end
        @(negedge clk);
        load(b2);
        load(b3);
        wait_beats(7, 60, ok);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++;
            if (fifo_rd_en !== 1'b0 || in_packet !== 1'b1) begin
                failures++;
                $display("FAIL enable_off%0d got rd=%b in_pkt=%b exp rd=0 in_pkt=1", k, fifo_rd_en, in_packet);
            end
            @(negedge clk);
        end
        enable = 1'b1;
        wait_beats(exp_q.size(), 80, ok);
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (!ok || obs.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stall_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if (rd_bad !== 0 || pkt_count !== 16'd2 || in_packet !== 1'b0) begin
            failures++;
            $display("FAIL stall_end got bad_rd=%0d count=%0d in_pkt=%b exp 0 2 0", rd_bad, pkt_count, in_packet);
        end
    endtask

    task automatic test_reset_mid();
        byte unsigned b[$];
        bit ok;
        do_reset();
        b = '{8'h04, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        load(b);
        wait_beats(2, 40, ok);
        checks++;
        if (!ok || in_packet !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pre got in_pkt=%b exp=1", in_packet);
        end
        reset_n = 1'b0;
        fq.delete();
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, m_data, m_last, pkt_err, pkt_count, in_packet} !== 30'h0) begin
            failures++;
            $display("FAIL rmid_outputs got rd=%b v=%b d=%h l=%b e=%b c=%0d p=%b exp all zero",
                     fifo_rd_en, m_valid, m_data, m_last, pkt_err, pkt_count, in_packet);
        end
        @(negedge clk);
        clear_obs();
        b = '{8'h03, 8'hF1, 8'hF2, 8'hF3};
        model_parse(b);
        load(b);
        reset_n = 1'b1;
        wait_beats(3, 40, ok);
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (!ok || obs.size() !== 3 || pkt_count !== 16'd1) begin
            failures++;
            $display("FAIL rmid_count got n=%0d count=%0d exp 3 and 1", obs.size(), pkt_count);
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rmid_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        byte unsigned all[$];
        byte unsigned pending[$];
        int len;
        int n;
        bit ok;
        do_reset();
        for (int p = 0; p < 14; p++) begin
            len = (p == 6) ? 255 : $urandom_range(0, 6);
            all.push_back(8'(len));
            for (int k = 0; k < len; k++) all.push_back(8'($urandom_range(0, 255)));
        end
        model_parse(all);
        pending = all;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (pending.size() == 0 && fq.size() == 0 && obs.size() >= exp_q.size()) break;
            m_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 4) != 0);
            stall_empty = ($urandom_range(0, 7) == 0);
            n = $urandom_range(0, 2);
            while (n > 0 && pending.size() > 0) begin
                fq.push_back(pending.pop_front());
                n--;
            end
        end
        m_ready = 1'b1;
        enable = 1'b1;
        stall_empty = 1'b0;
        while (pending.size() > 0) fq.push_back(pending.pop_front());
        wait_beats(exp_q.size(), 800, ok);
        repeat (4) @(negedge clk);
        #2;
        checks++;
        if (!ok || obs.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL rand_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if (pkt_count !== exp_pkts[15:0] || err_cycles !== exp_err) begin
            failures++;
            $display("FAIL rand_counts got count=%0d errs=%0d exp count=%0d errs=%0d",
                     pkt_count, err_cycles, exp_pkts, exp_err);
        end
        checks++;
        if (rd_bad !== 0 || hold_bad !== 0) begin
            failures++;
            $display("FAIL rand_protocol got bad_rd=%0d unstable=%0d exp 0 0", rd_bad, hold_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_zero_len();
        test_stall_enable();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_reader.md
Name: fifo_pkt_reader

Overview:
- Read-side master for the team's synchronous FIFO: drives the FIFO's rd_en and consumes its registered data_out.
- Parses length-prefixed packets from the byte stream: one header byte L, then L payload bytes.
- Emits the payload on a valid/ready stream with m_last; the header is not forwarded.
- Sits between the FIFO and any downstream packet consumer, and sustains one byte per cycle with no bubbles.

Parameters:
- DATA_WIDTH, 8, width of FIFO word, header and payload byte.
- CNT_WIDTH, 16, width of the completed-packet counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = permitted to issue new FIFO reads
- fifo_empty  in  1  FIFO empty flag
- fifo_data_out  in  DATA_WIDTH  FIFO read data, valid in the cycle after an accepted rd_en
- fifo_rd_en  out  1  FIFO read request
- m_data  out  DATA_WIDTH  payload byte
- m_valid  out  1  m_data/m_last valid
- m_ready  in  1  downstream accept
- m_last  out  1  final payload byte of the packet
- pkt_err  out  1  one-cycle pulse: zero-length header received
- pkt_count  out  CNT_WIDTH  packets fully handed off (last byte accepted)
- in_packet  out  1  parser state is PAYLOAD

Behaviour:
- Reset: async assert, sync release. All registers clear.
  - Output values in reset: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, pkt_err=0, pkt_count=0, in_packet=0.
  - Buffer and in-flight flag cleared; any byte in flight is discarded.
- FIFO read timing: fifo_rd_en asserted in cycle N with fifo_empty=0 means data is present on fifo_data_out in cycle N+1. The block registers inflight=1 for that cycle.
- Output buffer: 2-entry FIFO, each entry holding {data, last}. m_data/m_last come from the head entry; m_valid = (occ != 0). A pop occurs when m_valid && m_ready.
- Read issue (combinational):
  - fifo_rd_en = enable && !fifo_empty && (occ + inflight - pop) < 2.
  - This path from m_ready to fifo_rd_en is intentional: it gives full throughput with 2 entries.
  - The header byte also consumes a credit (conservative). The buffer must never overflow.
- Parser FSM, advanced only on arrival (inflight=1):
  - HDR: byte B is the header.
    - B==0: pkt_err=1 for one cycle, stay in HDR.
    - Otherwise remaining<=B, go to PAYLOAD.
    - The header is never pushed into the buffer.
  - PAYLOAD: push {byte, last=(remaining==1)} and decrement remaining.
    - When remaining==1, return to HDR.
  - remaining is DATA_WIDTH bits wide, so the maximum packet is 2^DATA_WIDTH-1 bytes.
- Simultaneous push and pop in the same cycle: occ is unchanged; head and tail advance correctly, including when occ==1.
- m_data/m_last must stay stable while m_valid && !m_ready.
- pkt_count increments when a pop has last=1; it wraps modulo 2^CNT_WIDTH.
- enable deassert: no new reads are issued. In-flight and buffered bytes still complete, and parser state is retained. A packet may therefore pause mid-payload and resume when enable returns.
- fifo_empty=1 mid-packet: reads stall and the parser stays in PAYLOAD. There is no timeout.
- fifo_empty is sampled only for issue. Arrival relies solely on inflight.
- Reset mid-packet: parser returns to HDR. The next byte read after reset is treated as a header. FIFO contents are the FIFO's own concern.

Decomposition:
- Shared package fifo_pkg:
  - typedef parse_state_t {HDR, PAYLOAD}
  - constant FIFO_RD_LATENCY = 1
  - typedef for buffer entry {data, last}
- One sub-module: pkt_skid_buf2. It is the 2-entry {data,last} buffer with push/pop/occ, reusable elsewhere.
- The FSM, credit logic and counter stay in the top.

Test Plan:
- Single packet: FIFO holds 03,A1,A2,A3 with m_ready=1. Expect m_data A1,A2,A3 on consecutive cycles, m_last only on A3, pkt_count=1, in_packet low afterwards, header 03 never on m_data.
- Back-to-back throughput: FIFO holds 02,11,12,01,21 with m_ready=1. Expect 11,12,21 with no bubble between 12 and 21 (beyond the one header cycle), m_last on 12 and 21, pkt_count=2.
- Backpressure: a 4-byte packet with m_ready low for 5 cycles mid-packet. Expect occ<=2, fifo_rd_en low while credits are exhausted, m_data held stable, no byte lost or duplicated, order preserved.
- Zero length: FIFO holds 00,01,5A. Expect a pkt_err pulse for exactly one cycle, then 5A with m_last=1, pkt_count=1.
- Stall and enable: FIFO runs empty after 2 of 5 payload bytes, then refills. Separately, enable is dropped for 3 cycles mid-packet. Expect no rd_en while empty or disabled, in_packet stays 1, the packet completes correctly.
- Reset mid-packet: assert reset_n=0 after 2 of 4 payload bytes. Expect all outputs 0 immediately; after release, the next FIFO byte (03) is parsed as a header and 3 bytes follow with correct m_last.
